// File: rtl/fir_out_stream.sv
// fir_out_stream: output stage for the FIR filter.
// Discards the first SKIP samples after reset while the filter delay line fills.
// After that it buffers samples in a first-word-fall-through FIFO and tags
// every FRAME_LEN-th accepted sample as the end of a frame.
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous, active-low reset
//   y_in       signed Q4.12 filter output sample
//   y_valid    y_in carries a new sample this cycle
//   m_data     head-of-FIFO sample (0 when empty)
//   m_valid    m_data/m_last valid (FIFO not empty)
//   m_ready    downstream accepts the head entry
//   m_last     head entry closes a frame
//   overflow   sticky: a sample was dropped because the FIFO was full
//   clear_ovf  clears overflow (a coincident drop wins)
//   level      current FIFO occupancy
module fir_out_stream #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SKIP      = 8,
  parameter int unsigned FRAME_LEN = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic signed [DATA_W-1:0]  y_in,
  input  logic                      y_valid,
  output logic signed [DATA_W-1:0]  m_data,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic                      m_last,
  output logic                      overflow,
  input  logic                      clear_ovf,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PTR_W     = $clog2(DEPTH);
  localparam int unsigned LVL_W     = PTR_W + 1;
  localparam int unsigned SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
  localparam int unsigned SKIP_LAST = (SKIP > 0) ? (SKIP - 1) : 0;
  localparam int unsigned FRM_W     = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned FRM_LAST  = FRAME_LEN - 1;

  typedef enum logic {
    WARMUP = 1'b0,
    RUN    = 1'b1
  } state_t;

  // One FIFO slot: the sample plus its end-of-frame marker.
  typedef struct packed {
    logic              last;
    logic [DATA_W-1:0] data;
  } entry_t;

  state_t             state_q, state_d;
  logic [SKIP_W-1:0]  skip_q, skip_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [FRM_W-1:0]   frm_q, frm_d;
  logic               ovf_q, ovf_d;

  logic               running;
  logic               full;
  logic               push;
  logic               pop;
  logic               drop;
  logic               frm_last;
  entry_t             head;
  entry_t             mem [DEPTH];

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if (SKIP == 0) state_q <= RUN;
      else           state_q <= WARMUP;
      skip_q <= '0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
    end
  end

  // Warm-up sequencing: count discarded samples, leave on the SKIPth one.
  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    unique case (state_q)
      WARMUP: begin
        if (y_valid) begin
          if (skip_q == SKIP_W'(SKIP_LAST)) begin
            state_d = RUN;
            skip_d  = '0;
          end else begin
            skip_d = skip_q + SKIP_W'(1);
          end
        end
      end
      RUN: begin
        state_d = RUN;
      end
      default: begin
        state_d = state_q;
      end
    endcase
  end

  // FIFO handshake decode; a pop frees the slot a same-cycle push needs.
  always_comb begin
    running  = (state_q == RUN);
    full     = (level_q == LVL_W'(DEPTH));
    m_valid  = (level_q != '0);
    pop      = m_valid && m_ready;
    push     = running && y_valid && (!full || pop);
    drop     = running && y_valid && full && !pop;
    frm_last = (frm_q == FRM_W'(FRM_LAST));
  end

  // Next-state for pointers, occupancy, frame index and sticky overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    frm_d    = frm_q;
    ovf_d    = ovf_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      frm_d    = frm_last ? '0 : frm_q + FRM_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase

    // A drop in the same cycle as clear_ovf keeps the flag set.
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clear_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // Control registers; reset discards all buffered samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      frm_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      frm_q    <= frm_d;
      ovf_q    <= ovf_d;
    end
  end

  // Sample storage; contents are only observed through level-gated reads.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= entry_t'{last: frm_last, data: y_in};
    end
  end

  // First-word-fall-through head, forced to zero while empty.
  always_comb begin
    head   = mem[rd_ptr_q];
    m_data = m_valid ? head.data : '0;
    m_last = m_valid && head.last;
  end

  assign overflow = ovf_q;
  assign level    = level_q;

endmodule

// File: tb/tb_fir_out_stream.sv
// Self-checking bench for fir_out_stream at default parameters.
module tb_fir_out_stream;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned DEPTH     = 8;
  localparam int unsigned SKIP      = 8;
  localparam int unsigned FRAME_LEN = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic signed [DATA_W-1:0] y_in;
  logic                     y_valid;
  logic signed [DATA_W-1:0] m_data;
  logic                     m_valid;
  logic                     m_ready;
  logic                     m_last;
  logic                     overflow;
  logic                     clear_ovf;
  logic [3:0]               level;

  fir_out_stream #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .SKIP     (SKIP),
    .FRAME_LEN(FRAME_LEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .y_in     (y_in),
    .y_valid  (y_valid),
    .m_data   (m_data),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_last   (m_last),
    .overflow (overflow),
    .clear_ovf(clear_ovf),
    .level    (level)
  );

  always #5 clk = ~clk;

  // Scoreboard entry: what the head of the FIFO must show.
  typedef struct packed {
    logic [15:0] data;
    logic        last;
  } exp_t;

  // Table vector: one cycle of stimulus plus post-edge level/overflow.
  typedef struct {
    logic        yv;
    logic [15:0] y;
    logic        rdy;
    logic        clr;
    int          exp_level;
    logic        exp_ovf;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];

  int checks = 0;
  int errors = 0;

  bit run_m;
  int skip_m;
  int frm_m;
  bit ovf_m;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    run_m  = (SKIP == 0);
    skip_m = 0;
    frm_m  = 0;
    ovf_m  = 1'b0;
  endtask

  // Drive one cycle: check head before the edge, advance the model, check after.
  task automatic cycle(input logic yv, input logic [15:0] y, input logic rdy, input logic clr);
    bit pop_m, push_m, full_m;
    exp_t e;
    y_valid   = yv;
    y_in      = y;
    m_ready   = rdy;
    clear_ovf = clr;
    #2;
    if (sb.size() != 0) begin
      chk("head_valid", {31'b0, m_valid}, 32'd1);
      chk("head_data", {16'h0, m_data}, {16'h0, sb[0].data});
      chk("head_last", {31'b0, m_last}, {31'b0, sb[0].last});
    end else begin
      chk("empty_valid", {31'b0, m_valid}, 32'd0);
      chk("empty_data", {16'h0, m_data}, 32'd0);
      chk("empty_last", {31'b0, m_last}, 32'd0);
    end
    pop_m  = (sb.size() != 0) && rdy;
    full_m = (sb.size() == DEPTH);
    push_m = run_m && yv && (!full_m || pop_m);
    if (pop_m) void'(sb.pop_front());
    if (push_m) begin
      e.data = y;
      e.last = (frm_m == FRAME_LEN - 1);
      sb.push_back(e);
      frm_m = (frm_m == FRAME_LEN - 1) ? 0 : frm_m + 1;
    end
    if (run_m && yv && full_m && !pop_m) ovf_m = 1'b1;
    else if (clr)                        ovf_m = 1'b0;
    if (!run_m && yv) begin
      skip_m++;
      if (skip_m == SKIP) run_m = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("level", {28'b0, level}, sb.size());
    chk("overflow", {31'b0, overflow}, {31'b0, ovf_m});
  endtask

  task automatic add(input logic yv, input logic [15:0] y, input logic rdy, input logic clr,
                     input int lvl, input logic ovf);
    vec_t v;
    v.yv = yv; v.y = y; v.rdy = rdy; v.clr = clr; v.exp_level = lvl; v.exp_ovf = ovf;
    vecs.push_back(v);
  endtask

  initial begin
    rst       = 1'b0;
    y_in      = '0;
    y_valid   = 1'b0;
    m_ready   = 1'b0;
    clear_ovf = 1'b0;
    model_reset();

    // Reset values.
    #12;
    chk("rst_valid", {31'b0, m_valid}, 32'd0);
    chk("rst_data", {16'h0, m_data}, 32'd0);
    chk("rst_last", {31'b0, m_last}, 32'd0);
    chk("rst_ovf", {31'b0, overflow}, 32'd0);
    chk("rst_level", {28'b0, level}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Warm-up: eight samples vanish, the ninth appears one cycle later.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'h1000, 1'b1, 1'b0);
      chk("warm_valid", {31'b0, m_valid}, 32'd0);
    end
    cycle(1'b1, 16'h0ABC, 1'b1, 1'b0);
    chk("warm_first_valid", {31'b0, m_valid}, 32'd1);
    chk("warm_first_data", {16'h0, m_data}, 32'h0ABC);
    cycle(1'b0, 16'h0, 1'b1, 1'b0);

    // Fill to five, then reset in the middle of a clock period.
    for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h0100 + i), 1'b0, 1'b0);
    chk("pre_rst_level", {28'b0, level}, 32'd5);
    y_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    chk("async_valid", {31'b0, m_valid}, 32'd0);
    chk("async_level", {28'b0, level}, 32'd0);
    chk("async_data", {16'h0, m_data}, 32'd0);
    model_reset();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Warm-up restarts after the reset.
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 16'(16'h2000 + i), 1'b0, 1'b0);
      chk("rewarm_valid", {31'b0, m_valid}, 32'd0);
    end

    // Overflow, sticky flag, full push+pop, drain, framing, empty pops.
    for (int i = 1; i <= 9; i++) add(1'b1, 16'(i), 1'b0, 1'b0, (i > 8) ? 8 : i, (i > 8));
    add(1'b1, 16'h00AA, 1'b0, 1'b1, 8, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b1, 8, 1'b0);
    add(1'b1, 16'h0010, 1'b1, 1'b0, 8, 1'b0);
    for (int i = 7; i >= 0; i--) add(1'b0, 16'h0000, 1'b1, 1'b0, i, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
    add(1'b1, 16'h0011, 1'b1, 1'b0, 1, 1'b0);
    add(1'b1, 16'hF123, 1'b1, 1'b0, 1, 1'b0);
    add(1'b1, 16'h0013, 1'b1, 1'b0, 1, 1'b0);
    add(1'b1, 16'h0014, 1'b1, 1'b0, 1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b0, 0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].yv, vecs[i].y, vecs[i].rdy, vecs[i].clr);
      chk($sformatf("vec%0d_level", i), {28'b0, level}, 32'(vecs[i].exp_level));
      chk($sformatf("vec%0d_ovf", i), {31'b0, overflow}, {31'b0, vecs[i].exp_ovf});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
